// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full_add cell sequenced over WIDTH cycles, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_ADD_CTRL_OVF_EN.

module full_add (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_CTRL_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sha_q, sha_d;
  logic [WIDTH-1:0]   shb_q, shb_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               fa_s, fa_cout;
`ifdef SERIAL_ADD_CTRL_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  full_add u_fa (
    .a    (sha_q[0]),
    .b    (shb_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  always_comb begin
    state_d = state_q;
    sha_d   = sha_q;
    shb_d   = shb_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADD_CTRL_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sha_d   = a;
          shb_d   = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        sha_d   = {1'b0, sha_q[WIDTH-1:1]};
        shb_d   = {1'b0, shb_q[WIDTH-1:1]};
        carry_d = fa_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          cout_d  = fa_cout;
`ifdef SERIAL_ADD_CTRL_OVF_EN
          // carry into MSB xor carry out of MSB
          ovf_d   = carry_q ^ fa_cout;
`endif
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sha_q   <= '0;
      shb_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADD_CTRL_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sha_q   <= sha_d;
      shb_q   <= shb_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADD_CTRL_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADD_CTRL_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: WIDTH=8 directed vectors and a WIDTH=2 exhaustive sweep.

module tb_serial_add_ctrl;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } exp8_t;

  typedef struct {
    logic [2:0] res;
    logic       ovf;
  } exp2_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;
  logic       start2 = 1'b0, cin2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       busy2, done2, cout2;
  logic [1:0] sum2;
`ifdef SERIAL_ADD_CTRL_OVF_EN
  logic       ovf8, ovf2;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done8_cnt = 0;
  int last_done2 = -1;
  exp8_t q8[$];
  exp2_t q2[$];

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
`ifdef SERIAL_ADD_CTRL_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_add_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
`ifdef SERIAL_ADD_CTRL_OVF_EN
    , .ovf(ovf2)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // WIDTH=8 monitor
  always @(negedge clk) begin
    if (done8) begin
      exp8_t e;
      done8_cnt++;
      if (q8.size() == 0) begin
        checks++; errors++;
        $display("FAIL done8_unexpected: got done with sum=%0h, expected no done", sum8);
      end else begin
        e = q8.pop_front();
        check("sum8", {24'd0, sum8}, {24'd0, e.sum});
        check("cout8", {31'd0, cout8}, {31'd0, e.cout});
`ifdef SERIAL_ADD_CTRL_OVF_EN
        check("ovf8", {31'd0, ovf8}, {31'd0, e.ovf});
`endif
      end
    end
  end

  // WIDTH=2 monitor
  always @(negedge clk) begin
    if (done2) begin
      exp2_t e;
      if (q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL done2_unexpected: got done with res=%0h, expected no done", {cout2, sum2});
      end else begin
        e = q2.pop_front();
        check("res2", {29'd0, cout2, sum2}, {29'd0, e.res});
`ifdef SERIAL_ADD_CTRL_OVF_EN
        check("ovf2", {31'd0, ovf2}, {31'd0, e.ovf});
`endif
        if (last_done2 >= 0) check("done2_spacing", cyc - last_done2, 4);
      end
      last_done2 = cyc;
    end
  end

  task automatic run8(input logic [7:0] ai, input logic [7:0] bi, input logic ci,
                      input logic [7:0] es, input logic ec, input logic eo);
    int k, bc;
    exp8_t e;
    @(negedge clk);
    a8 = ai; b8 = bi; cin8 = ci; start8 = 1'b1;
    e.sum = es; e.cout = ec; e.ovf = eo;
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
    a8 = ~ai; b8 = ~bi; cin8 = ~ci;
    k = 0;
    bc = busy8 ? 1 : 0;
    while (!done8 && k < 40) begin
      @(negedge clk);
      k++;
      if (busy8) bc++;
    end
    @(negedge clk);
    if (busy8) bc++;
    check("latency8", k, 8);
    check("busy_cycles8", bc, 9);
    repeat (2) @(negedge clk);
    check("sum8_hold", {24'd0, sum8}, {24'd0, es});
  endtask

  initial begin
    int base, w;
    exp2_t e2;
    exp8_t e8;
    repeat (2) @(negedge clk);
    check("rst_busy8", {31'd0, busy8}, 0);
    check("rst_done8", {31'd0, done8}, 0);
    check("rst_sum8", {24'd0, sum8}, 0);
    check("rst_cout8", {31'd0, cout8}, 0);
    check("rst_busy2", {31'd0, busy2}, 0);
    rst = 1'b0;

    run8(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run8(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
    run8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run8(8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, 1'b0);

    // start during RUN is ignored, inputs change mid-run
    base = done8_cnt;
    @(negedge clk);
    a8 = 8'h05; b8 = 8'h03; cin8 = 1'b0; start8 = 1'b1;
    e8.sum = 8'h08; e8.cout = 1'b0; e8.ovf = 1'b0;
    q8.push_back(e8);
    @(negedge clk); start8 = 1'b0;
    repeat (2) @(negedge clk);
    a8 = 8'hAA; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'h33; b8 = 8'hCC; cin8 = 1'b1;
    w = 0;
    while (done8_cnt == base && w < 30) begin @(negedge clk); w++; end
    repeat (12) @(negedge clk);
    check("single_done8", done8_cnt - base, 1);
    check("q8_empty_mid", q8.size(), 0);

    // asynchronous reset mid-run
    base = done8_cnt;
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_busy8", {31'd0, busy8}, 1);
    #2 rst = 1'b1;
    #1;
    check("abort_busy8", {31'd0, busy8}, 0);
    check("abort_done8", {31'd0, done8}, 0);
    check("abort_sum8", {24'd0, sum8}, 0);
    check("abort_cout8", {31'd0, cout8}, 0);
`ifdef SERIAL_ADD_CTRL_OVF_EN
    check("abort_ovf8", {31'd0, ovf8}, 0);
`endif
    @(negedge clk); rst = 1'b0;
    repeat (12) @(negedge clk);
    check("no_done_after_abort", done8_cnt - base, 0);
    run8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);

    // WIDTH=2 exhaustive sweep with start held high
    for (int i = 0; i < 32; i++) begin
      logic [1:0] ai, bi;
      logic       ci;
      logic [2:0] r;
      ai = i[4:3]; bi = i[2:1]; ci = i[0];
      r = {1'b0, ai} + {1'b0, bi} + {2'b00, ci};
      @(negedge clk);
      a2 = ai; b2 = bi; cin2 = ci; start2 = 1'b1;
      e2.res = r;
      e2.ovf = (ai[1] == bi[1]) && (r[1] != ai[1]);
      q2.push_back(e2);
      repeat (3) @(negedge clk);
    end
    @(negedge clk);
    start2 = 1'b0;
    w = 0;
    while (q2.size() != 0 && w < 20) begin @(negedge clk); w++; end
    repeat (6) @(negedge clk);
    check("q2_drained", q2.size(), 0);
    check("q8_drained", q8.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
